// File: rtl/mod_99_8a_verify_if.sv
// MAC Merge verify handshake bundle: management/PHY controls, mPacket pulses and status.
// master = verify block, slave = surrounding MMS logic; pulses are single-cycle, send_v is a level.
interface mod_99_8a_verify_if;
  logic       p_mac_merge_en_tx;
  logic       disable_verify;
  logic       link_fail;
  logic [7:0] verify_time;
  logic       rcv_r;
  logic       send_v_done;
  logic       send_v;
  logic       verified;
  logic       verify_fail;
  logic [2:0] verify_cnt;
  logic [2:0] verify_status;
  logic [2:0] mod_99_8a_state;

  modport master (
    input  p_mac_merge_en_tx, disable_verify, link_fail, verify_time, rcv_r, send_v_done,
    output send_v, verified, verify_fail, verify_cnt, verify_status, mod_99_8a_state
  );

  modport slave (
    output p_mac_merge_en_tx, disable_verify, link_fail, verify_time, rcv_r, send_v_done,
    input  send_v, verified, verify_fail, verify_cnt, verify_status, mod_99_8a_state
  );
endinterface

// File: rtl/mod_99_8a_verify.sv
// Preemption verify initiator: sends verify mPackets, times each respond wait, retries, reports status.
// Registered outputs; send_v is held until send_v_done (no other backpressure); any abort resets in one cycle.
module mod_99_8a_verify #(
  parameter int CYCLES_PER_MS = 125000,
  parameter int VERIFY_LIMIT  = 3
) (
  input  logic                clk,
  input  logic                reset_begin,
  mod_99_8a_verify_if.master  bus
);

  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_MS - 1);
  localparam logic [2:0]    LIMIT     = 3'(VERIFY_LIMIT);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT     = 3'd3,
    S_VERIFIED = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_INITIAL   = 3'd1,
    ST_VERIFYING = 3'd2,
    ST_SUCCEEDED = 3'd3,
    ST_FAILED    = 3'd4
  } status_t;

  state_t        state;
  state_t        next_state;
  logic          in_entry;
  logic          send_v_q;
  logic          verified_q;
  logic          fail_q;
  logic [2:0]    cnt_q;
  logic          resp_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    ms_q;
  logic          run_q;
  logic          expire_q;
  logic          pending_q;

  logic          abort;
  logic          clr;
  logic          load;
  logic          done_ok;
  logic          timeout;
  logic [7:0]    vt_ms;
  status_t       status;

  assign abort   = bus.link_fail | bus.disable_verify | ~bus.p_mac_merge_en_tx;
  // send_v_done only counts once send_v is actually up (never in the entry cycle)
  assign done_ok = bus.send_v_done & send_v_q;
  assign timeout = expire_q | pending_q;

  always_comb begin
    vt_ms = bus.verify_time;
    if (bus.verify_time == 8'd0) begin
      vt_ms = 8'd1;
    end else if (bus.verify_time > 8'd128) begin
      vt_ms = 8'd128;
    end
  end

  always_comb begin
    next_state = state;
    if (reset_begin || abort) begin
      next_state = S_INIT;
    end else begin
      case (state)
        S_INIT: next_state = S_IDLE;
        S_IDLE: next_state = S_SEND;
        S_SEND: begin
          if (done_ok) begin
            next_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_q || bus.rcv_r) begin
            next_state = S_VERIFIED;
          end else if (timeout) begin
            next_state = (cnt_q >= LIMIT) ? S_FAIL : S_SEND;
          end
        end
        S_VERIFIED: next_state = S_VERIFIED;
        S_FAIL:     next_state = S_FAIL;
        default:    next_state = S_INIT;
      endcase
    end
  end

  // Reset and abort both land in INIT, so one clear term covers every register.
  assign clr  = (next_state == S_INIT);
  assign load = in_entry && (next_state == S_SEND);

  always_ff @(posedge clk) begin
    state      <= next_state;
    in_entry   <= (next_state == S_SEND) && (state != S_SEND);
    verified_q <= (next_state == S_VERIFIED);
    fail_q     <= (next_state == S_FAIL);

    if (next_state != S_SEND) begin
      send_v_q <= 1'b0;
    end else if (load) begin
      send_v_q <= 1'b1;
    end

    if (clr) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= cnt_q + 3'd1;
    end

    if (clr || load) begin
      resp_q <= 1'b0;
    end else if (bus.rcv_r && (((state == S_SEND) && !in_entry) || (state == S_WAIT))) begin
      resp_q <= 1'b1;
    end
  end

  // Expiry lands exactly vt_ms*CYCLES_PER_MS edges after the load edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q  <= '0;
      ms_q     <= 8'd0;
      run_q    <= 1'b0;
      expire_q <= 1'b0;
    end else if (load) begin
      presc_q  <= PRESC_MAX;
      ms_q     <= vt_ms - 8'd1;
      run_q    <= 1'b1;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (run_q) begin
        if (presc_q == '0) begin
          if (ms_q == 8'd0) begin
            expire_q <= 1'b1;
            run_q    <= 1'b0;
          end else begin
            ms_q    <= ms_q - 8'd1;
            presc_q <= PRESC_MAX;
          end
        end else begin
          presc_q <= presc_q - 1'b1;
        end
      end
    end
  end

  // An expiry seen while the verify is still being transmitted waits for WAIT_FOR_RESPONSE.
  always_ff @(posedge clk) begin
    if (clr || load) begin
      pending_q <= 1'b0;
    end else if (state == S_SEND) begin
      pending_q <= pending_q | expire_q;
    end else begin
      pending_q <= 1'b0;
    end
  end

  always_comb begin
    status = ST_INITIAL;
    if (bus.disable_verify || !bus.p_mac_merge_en_tx) begin
      status = ST_DISABLED;
    end else if (state == S_VERIFIED) begin
      status = ST_SUCCEEDED;
    end else if (state == S_FAIL) begin
      status = ST_FAILED;
    end else if ((state == S_SEND) || (state == S_WAIT)) begin
      status = ST_VERIFYING;
    end
  end

  assign bus.send_v          = send_v_q;
  assign bus.verified        = verified_q;
  assign bus.verify_fail     = fail_q;
  assign bus.verify_cnt      = cnt_q;
  assign bus.verify_status   = status;
  assign bus.mod_99_8a_state = state;

endmodule

// File: tb/tb_mod_99_8a_verify.sv
// Directed bench for the MAC Merge verify initiator: per-cycle vector table plus hand-built timer sequences.
module tb_mod_99_8a_verify;

  logic clk = 1'b0;
  logic reset_begin;

  mod_99_8a_verify_if bus();

  mod_99_8a_verify #(
    .CYCLES_PER_MS (4),
    .VERIFY_LIMIT  (3)
  ) dut (
    .clk         (clk),
    .reset_begin (reset_begin),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst, en, dis, lf, rcv, done;
    logic [2:0] st;
    logic       sv, vd, vf;
    logic [2:0] cnt, status;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic dis, input logic lf,
                     input logic rcv, input logic done, input logic [2:0] st,
                     input logic sv, input logic vd, input logic vf,
                     input logic [2:0] cnt, input logic [2:0] status);
    vec_t v;
    v.rst = rst; v.en = en; v.dis = dis; v.lf = lf; v.rcv = rcv; v.done = done;
    v.st = st; v.sv = sv; v.vd = vd; v.vf = vf; v.cnt = cnt; v.status = status;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset then walk to the timer-load edge; returns with send_v=1, verify_cnt=1.
  task automatic restart(input string tag);
    reset_begin = 1'b1;
    bus.rcv_r = 1'b0;
    bus.send_v_done = 1'b0;
    tick;
    reset_begin = 1'b0;
    tick;
    chk({tag, "_idle"}, bus.mod_99_8a_state, 1);
    tick;
    chk({tag, "_entry"}, bus.mod_99_8a_state, 2);
    chk({tag, "_entry_sv"}, bus.send_v, 0);
    tick;
    chk({tag, "_load_sv"}, bus.send_v, 1);
    chk({tag, "_load_cnt"}, bus.verify_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_begin = 1'b1;
    bus.p_mac_merge_en_tx = 1'b1;
    bus.disable_verify = 1'b0;
    bus.link_fail = 1'b0;
    bus.verify_time = 8'd2;
    bus.rcv_r = 1'b0;
    bus.send_v_done = 1'b0;

    // rst en dis lf rcv done | st sv vd vf cnt status
    add(1,1,0,0,0,0, 0,0,0,0,0,1);
    add(1,1,0,0,0,0, 0,0,0,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,0,0,2);
    for (int i = 0; i < 5; i++) add(0,1,0,0,0,0, 2,1,0,0,1,2);
    add(0,1,0,0,0,1, 3,0,0,0,1,2);
    add(0,1,0,0,0,0, 3,0,0,0,1,2);
    add(0,1,0,0,1,0, 4,0,1,0,1,3);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0,0, 4,0,1,0,1,3);
    add(0,1,0,1,0,0, 0,0,0,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,0,0,2);
    add(0,1,0,0,0,0, 2,1,0,0,1,2);
    add(0,1,0,1,0,0, 0,0,0,0,0,1);
    add(0,1,0,0,0,1, 1,0,0,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,0,0,2);
    add(0,1,0,0,0,0, 2,1,0,0,1,2);
    add(0,1,1,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0,0,1);

    foreach (vecs[i]) begin
      reset_begin           = vecs[i].rst;
      bus.p_mac_merge_en_tx = vecs[i].en;
      bus.disable_verify    = vecs[i].dis;
      bus.link_fail         = vecs[i].lf;
      bus.rcv_r             = vecs[i].rcv;
      bus.send_v_done       = vecs[i].done;
      tick;
      chk($sformatf("v%0d_state", i), bus.mod_99_8a_state, vecs[i].st);
      chk($sformatf("v%0d_send_v", i), bus.send_v, vecs[i].sv);
      chk($sformatf("v%0d_verified", i), bus.verified, vecs[i].vd);
      chk($sformatf("v%0d_verify_fail", i), bus.verify_fail, vecs[i].vf);
      chk($sformatf("v%0d_cnt", i), bus.verify_cnt, vecs[i].cnt);
      chk($sformatf("v%0d_status", i), bus.verify_status, vecs[i].status);
    end
    bus.rcv_r = 1'b0;
    bus.send_v_done = 1'b0;

    // Three unanswered attempts, 8-cycle timeout each, then VERIFY_FAIL.
    restart("retry");
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("retry%0d_sv", k), bus.send_v, 1);
      chk($sformatf("retry%0d_cnt", k), bus.verify_cnt, k);
      bus.send_v_done = 1'b1;
      tick;
      bus.send_v_done = 1'b0;
      chk($sformatf("retry%0d_wait", k), bus.mod_99_8a_state, 3);
      repeat (6) tick;
      chk($sformatf("retry%0d_l7", k), bus.mod_99_8a_state, 3);
      tick;
      chk($sformatf("retry%0d_l8", k), bus.mod_99_8a_state, 3);
      tick;
      if (k < 3) begin
        chk($sformatf("retry%0d_resend", k), bus.mod_99_8a_state, 2);
        tick;
      end else begin
        chk("fail_state", bus.mod_99_8a_state, 5);
        chk("fail_flag", bus.verify_fail, 1);
        chk("fail_status", bus.verify_status, 4);
        chk("fail_cnt", bus.verify_cnt, 3);
      end
    end
    repeat (3) tick;
    chk("fail_hold", bus.mod_99_8a_state, 5);
    chk("fail_hold_sv", bus.send_v, 0);

    // Respond in the same cycle as the first expiry wins.
    restart("race");
    bus.send_v_done = 1'b1;
    tick;
    bus.send_v_done = 1'b0;
    repeat (7) tick;
    bus.rcv_r = 1'b1;
    tick;
    bus.rcv_r = 1'b0;
    chk("race_state", bus.mod_99_8a_state, 4);
    chk("race_verified", bus.verified, 1);
    chk("race_cnt", bus.verify_cnt, 1);

    // Respond arriving before send_v_done is latched.
    restart("early");
    bus.rcv_r = 1'b1;
    tick;
    bus.rcv_r = 1'b0;
    chk("early_still_send", bus.mod_99_8a_state, 2);
    tick;
    bus.send_v_done = 1'b1;
    tick;
    bus.send_v_done = 1'b0;
    chk("early_wait", bus.mod_99_8a_state, 3);
    tick;
    chk("early_verified", bus.mod_99_8a_state, 4);
    chk("early_status", bus.verify_status, 3);

    // Expiry while still transmitting is held and acted on in the first WAIT cycle.
    restart("pend");
    repeat (8) tick;
    chk("pend_l8", bus.mod_99_8a_state, 2);
    tick;
    chk("pend_l9", bus.mod_99_8a_state, 2);
    bus.send_v_done = 1'b1;
    tick;
    bus.send_v_done = 1'b0;
    chk("pend_wait", bus.mod_99_8a_state, 3);
    tick;
    chk("pend_resend", bus.mod_99_8a_state, 2);
    tick;
    chk("pend_cnt2", bus.verify_cnt, 2);
    chk("pend_sv", bus.send_v, 1);

    // verify_time=0 acts as 1 ms; a later change must not affect the running timer.
    bus.verify_time = 8'd0;
    restart("vt0");
    bus.verify_time = 8'd2;
    bus.send_v_done = 1'b1;
    tick;
    bus.send_v_done = 1'b0;
    repeat (3) tick;
    chk("vt0_l4", bus.mod_99_8a_state, 3);
    tick;
    chk("vt0_l5", bus.mod_99_8a_state, 2);

    // verify_time=200 clamps to 128 ms = 512 cycles.
    bus.verify_time = 8'd200;
    restart("vt200");
    bus.send_v_done = 1'b1;
    tick;
    bus.send_v_done = 1'b0;
    repeat (511) tick;
    chk("vt200_l512", bus.mod_99_8a_state, 3);
    tick;
    chk("vt200_l513", bus.mod_99_8a_state, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
